// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if -- signal bundle between the OAM DMA controller and the
// surrounding CPU / system bus / PPU environment.
//   cpu_addr, cpu_we, cpu_data_out : CPU write cycle watched for the $4014 trigger
//   bus_data_in                    : system bus read data during a DMA read
//   rdy, busy, bus_master          : CPU halt / controller status
//   dma_addr, dma_rd               : DMA source read cycle
//   ppu_reg_cs, ppu_reg_addr,
//   ppu_data                       : OAMDATA write towards the PPU
// Modports: master = the DMA controller, slave = the environment driving it.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_data_out;
  logic [7:0]  bus_data_in;
  logic        rdy;
  logic        bus_master;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_data;
  logic        busy;

  modport master (
    input  cpu_addr, cpu_we, cpu_data_out, bus_data_in,
    output rdy, bus_master, dma_addr, dma_rd,
           ppu_reg_cs, ppu_reg_addr, ppu_data, busy
  );

  modport slave (
    output cpu_addr, cpu_we, cpu_data_out, bus_data_in,
    input  rdy, bus_master, dma_addr, dma_rd,
           ppu_reg_cs, ppu_reg_addr, ppu_data, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl -- sprite (OAM) DMA engine. A CPU write to $4014 halts the CPU
// and copies the 256-byte page {data,8'h00}..{data,8'hFF} into OAMDATA, one
// read cycle plus one write cycle per byte, with one extra alignment cycle
// when the halt lands on an odd CPU cycle.
// Ports:
//   clk     : CPU cycle clock
//   nres_in : asynchronous active-low reset
//   bus     : oam_dma_ctrl_if.master (CPU trigger in, DMA read, PPU write,
//             rdy/busy/bus_master status). All outputs decode registered
//             state only.
module oam_dma_ctrl (
  input  logic           clk,
  input  logic           nres_in,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  dat_q, dat_d;
  logic        par_q;
  logic        trigger;

  logic        rdy_c, busy_c, bus_master_c, dma_rd_c, ppu_reg_cs_c;
  logic [15:0] dma_addr_c;

  assign trigger = bus.cpu_we && (bus.cpu_addr == 16'h4014);

  // State register
  always_ff @(posedge clk or negedge nres_in) begin
    if (!nres_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = HALT;
      HALT:    state_d = par_q ? ALIGN : READ;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (idx_q == 8'hFF) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; idx saturates at $FF so the page never wraps.
  always_comb begin
    page_d = page_q;
    idx_d  = idx_q;
    dat_d  = dat_q;
    case (state_q)
      IDLE: if (trigger) begin
        page_d = bus.cpu_data_out;
        idx_d  = '0;
      end
      READ:  dat_d = bus.bus_data_in;
      WRITE: if (idx_q != 8'hFF) idx_d = idx_q + 8'd1;
      default: ;
    endcase
  end

  // Datapath registers; par is a free-running CPU cycle parity.
  always_ff @(posedge clk or negedge nres_in) begin
    if (!nres_in) begin
      page_q <= '0;
      idx_q  <= '0;
      dat_q  <= '0;
      par_q  <= 1'b0;
    end else begin
      page_q <= page_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      par_q  <= ~par_q;
    end
  end

  // Output decode from registered state
  always_comb begin
    rdy_c        = 1'b0;
    busy_c       = 1'b1;
    bus_master_c = 1'b0;
    dma_rd_c     = 1'b0;
    ppu_reg_cs_c = 1'b0;
    dma_addr_c   = '0;
    case (state_q)
      IDLE: begin
        rdy_c  = 1'b1;
        busy_c = 1'b0;
      end
      READ: begin
        bus_master_c = 1'b1;
        dma_rd_c     = 1'b1;
        dma_addr_c   = {page_q, idx_q};
      end
      WRITE: begin
        bus_master_c = 1'b1;
        ppu_reg_cs_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdy          = rdy_c;
  assign bus.busy         = busy_c;
  assign bus.bus_master   = bus_master_c;
  assign bus.dma_rd       = dma_rd_c;
  assign bus.dma_addr     = dma_addr_c;
  assign bus.ppu_reg_cs   = ppu_reg_cs_c;
  assign bus.ppu_reg_addr = 3'd4;
  assign bus.ppu_data     = dat_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl -- self-checking bench for oam_dma_ctrl. A transfer-level
// reference model (cycle offset within a DMA, plain arithmetic) predicts every
// output each cycle; table vectors and directed sequences cover the corners.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic nres_in = 1'b0;
  always #5 clk = ~clk;

  oam_dma_ctrl_if dif();

  oam_dma_ctrl dut (
    .clk     (clk),
    .nres_in (nres_in),
    .bus     (dif)
  );

  // System memory contents: fixed function of the address.
  function automatic logic [7:0] memval(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd7;
    return lo ^ (a[15:8] + 8'h3C);
  endfunction

  // Read data is garbage unless the DMA is actually reading.
  assign dif.bus_data_in = dif.dma_rd ? memval(dif.dma_addr) : 8'hC3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_active, m_align, m_par;
  logic [7:0] m_page, m_dat;
  int         m_cnt;

  task automatic model_reset();
    m_active = 1'b0; m_align = 1'b0; m_par = 1'b0;
    m_page = 8'h00; m_dat = 8'h00; m_cnt = 0;
  endtask

  // Returns byte offset k in the read/write phase, or -1 during HALT/ALIGN.
  function automatic int model_k();
    if (m_cnt == 0) return -1;
    if (m_align && m_cnt == 1) return -1;
    return m_cnt - 1 - (m_align ? 1 : 0);
  endfunction

  function automatic logic [31:0] model_out();
    logic [15:0] a;
    logic rd, cs, bm;
    int k;
    a = 16'h0000; rd = 1'b0; cs = 1'b0; bm = 1'b0;
    k = model_k();
    if (m_active && k >= 0) begin
      bm = 1'b1;
      if (k % 2 == 0) begin
        rd = 1'b1;
        a  = {m_page, 8'(k / 2)};
      end else begin
        cs = 1'b1;
      end
    end
    return {~m_active, m_active, bm, rd, cs, 3'd4, a, m_dat};
  endfunction

  task automatic model_step(input logic we, input logic [15:0] addr, input logic [7:0] data);
    int k;
    if (!nres_in) begin
      model_reset();
      return;
    end
    m_par = ~m_par;
    if (m_active) begin
      k = model_k();
      if (k >= 0 && k % 2 == 0) m_dat = memval({m_page, 8'(k / 2)});
      m_cnt++;
      if (m_cnt == (m_align ? 514 : 513)) m_active = 1'b0;
    end else if (we && addr == 16'h4014) begin
      m_active = 1'b1;
      m_page   = data;
      m_cnt    = 0;
      m_align  = m_par;
    end
  endtask

  // ---------------- per-cycle driver/checker ----------------
  logic        s_rdy, s_busy, s_bm, s_rd, s_cs;
  logic [2:0]  s_ra;
  logic [15:0] s_addr;
  logic [7:0]  s_data;

  task automatic cycle(input logic we, input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    s_rdy = dif.rdy; s_busy = dif.busy; s_bm = dif.bus_master; s_rd = dif.dma_rd;
    s_cs = dif.ppu_reg_cs; s_ra = dif.ppu_reg_addr; s_addr = dif.dma_addr; s_data = dif.ppu_data;
    chk("cycle_outputs", {s_rdy, s_busy, s_bm, s_rd, s_cs, s_ra, s_addr, s_data}, model_out());
    dif.cpu_we = we; dif.cpu_addr = addr; dif.cpu_data_out = data;
    @(posedge clk);
    model_step(we, addr, data);
  endtask

  // Idle until the trigger edge will leave par == halt_par in HALT.
  task automatic wait_par(input logic halt_par);
    for (int g = 0; g < 4 && (m_par == halt_par); g++) cycle(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic dma_run(input logic [7:0] pg, input logic halt_par, input logic inject,
                         output int low, output int cs, output int aln, output int bad,
                         output logic [15:0] lastaddr, output int foreign);
    low = 0; cs = 0; aln = 0; bad = 0; lastaddr = 16'h0000; foreign = 0;
    wait_par(halt_par);
    cycle(1'b1, 16'h4014, pg);
    for (int g = 0; g < 700; g++) begin
      cycle(inject && g == 200, 16'h4014, 8'h33);
      if (s_rdy) break;
      low++;
      if (g > 0 && !s_bm) aln++;
      if (s_cs) begin
        if (s_data !== memval({pg, 8'(cs)})) bad++;
        cs++;
      end
      if (s_rd) begin
        lastaddr = s_addr;
        if (s_addr[15:8] != pg) foreign++;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[6];

  int low, cs, aln, bad, foreign;
  logic [15:0] lastaddr;

  initial begin
    vecs[0] = '{1'b1, 16'h4013, 8'h02, 1'b0};
    vecs[1] = '{1'b1, 16'h2014, 8'h02, 1'b0};
    vecs[2] = '{1'b0, 16'h4014, 8'h02, 1'b0};
    vecs[3] = '{1'b1, 16'h4015, 8'h07, 1'b0};
    vecs[4] = '{1'b1, 16'h0014, 8'h07, 1'b0};
    vecs[5] = '{1'b1, 16'h4014, 8'h05, 1'b1};

    dif.cpu_we = 1'b0; dif.cpu_addr = 16'h0000; dif.cpu_data_out = 8'h00;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4014, 8'h11);
    chk("reset_rdy", s_rdy, 1);
    chk("reset_busy", s_busy, 0);
    chk("reset_ppu_reg_addr", s_ra, 3'd4);
    chk("reset_ppu_data", s_data, 8'h00);
    #2 nres_in = 1'b1;
    cycle(1'b0, 16'h0000, 8'h00);

    // Non-trigger writes, then a real trigger
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].data);
      #1;
      chk("tbl_busy", dif.busy, vecs[i].exp_busy);
      chk("tbl_rdy", dif.rdy, !vecs[i].exp_busy);
    end
    for (int g = 0; g < 600 && m_active; g++) cycle(1'b0, 16'h0000, 8'h00);
    cycle(1'b0, 16'h0000, 8'h00);
    chk("tbl_dma_done", s_rdy, 1);

    // Page $02, even HALT parity: 513 cycles
    dma_run(8'h02, 1'b0, 1'b0, low, cs, aln, bad, lastaddr, foreign);
    chk("even_len", low, 513);
    chk("even_writes", cs, 256);
    chk("even_align", aln, 0);
    chk("even_data", bad, 0);
    chk("even_last_addr", lastaddr, 16'h02FF);
    chk("even_foreign", foreign, 0);

    // Page $02, odd HALT parity: 514 cycles with one ALIGN
    dma_run(8'h02, 1'b1, 1'b0, low, cs, aln, bad, lastaddr, foreign);
    chk("odd_len", low, 514);
    chk("odd_writes", cs, 256);
    chk("odd_align", aln, 1);
    chk("odd_data", bad, 0);

    // Page $FF: no wrap into $00xx
    dma_run(8'hFF, 1'b0, 1'b0, low, cs, aln, bad, lastaddr, foreign);
    chk("ff_last_addr", lastaddr, 16'hFFFF);
    chk("ff_foreign", foreign, 0);
    chk("ff_writes", cs, 256);
    chk("ff_idle", s_busy, 0);

    // Second trigger mid-DMA is ignored
    dma_run(8'h10, 1'b1, 1'b1, low, cs, aln, bad, lastaddr, foreign);
    chk("inj_writes", cs, 256);
    chk("inj_foreign", foreign, 0);
    chk("inj_data", bad, 0);
    chk("inj_len", low, 514);

    // Asynchronous reset at byte 100
    cs = 0;
    cycle(1'b1, 16'h4014, 8'h05);
    for (int g = 0; g < 400 && cs < 100; g++) begin
      cycle(1'b0, 16'h0000, 8'h00);
      if (s_cs) cs++;
    end
    chk("rst_reached_100", cs, 100);
    #2 nres_in = 1'b0;
    #1;
    chk("rst_async_rdy", dif.rdy, 1);
    chk("rst_async_cs", dif.ppu_reg_cs, 0);
    chk("rst_async_busy", dif.busy, 0);
    chk("rst_async_bm", dif.bus_master, 0);
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 8'h00);
    #2 nres_in = 1'b1;
    cs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0000, 8'h00);
      if (s_cs || !s_rdy) cs++;
    end
    chk("rst_no_activity", cs, 0);
    dma_run(8'h44, 1'b0, 1'b0, low, cs, aln, bad, lastaddr, foreign);
    chk("rst_retrigger_writes", cs, 256);
    chk("rst_retrigger_len", low, 513);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic w;
      case ($urandom_range(3))
        0, 1:    a = 16'h4014;
        2:       a = ($urandom_range(1)) ? 16'h4013 : 16'h2014;
        default: a = 16'($urandom);
      endcase
      w = ($urandom_range(15) == 0);
      cycle(w, a, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; one clk period is one CPU cycle.
REQ-002 SHALL have port nres_in  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cpu_addr  input  16  CPU address bus.
REQ-004 SHALL have port cpu_we  input  1  CPU write strobe, valid for one clk.
REQ-005 SHALL have port cpu_data_out  input  8  CPU write data.
REQ-006 SHALL have port bus_data_in  input  8  read data returned from the system bus during a DMA read.
REQ-007 SHALL have port rdy  output  1  CPU ready; 0 halts the CPU.
REQ-008 SHALL have port bus_master  output  1  1 while DMA owns the address bus.
REQ-009 SHALL have port dma_addr  output  16  DMA source address.
REQ-010 SHALL have port dma_rd  output  1  DMA read strobe.
REQ-011 SHALL have port ppu_reg_cs  output  1  PPU register write strobe.
REQ-012 SHALL have port ppu_reg_addr  output  3  PPU register index, constant 3'd4 (OAMDATA).
REQ-013 SHALL have port ppu_data  output  8  data written to OAMDATA.
REQ-014 SHALL have port busy  output  1  1 in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE, with page register page[7:0], index register idx[7:0], data latch dat[7:0] and cycle-parity bit par.
REQ-016 SHALL toggle par on every clk edge, free-running, independent of state.
REQ-017 SHALL trigger in IDLE when cpu_we=1 and cpu_addr=16'h4014 at a clk edge: load page<=cpu_data_out, set idx<=0, and go to HALT.
REQ-018 SHALL ignore a $4014 write received in any state other than IDLE.
REQ-019 SHALL ignore writes to any address other than $4014.
REQ-020 HALT (1 cycle): SHALL go to ALIGN if par=1 during HALT, otherwise to READ.
REQ-021 ALIGN (1 cycle): SHALL go to READ.
REQ-022 READ (1 cycle): SHALL drive dma_addr={page,idx} and dma_rd=1, capture dat<=bus_data_in at the closing edge, and go to WRITE.
REQ-023 WRITE (1 cycle): SHALL drive ppu_reg_cs=1 with ppu_data=dat; if idx=8'hFF, SHALL go to IDLE, otherwise SHALL increment idx and go to READ.
REQ-024 SHALL complete one DMA in exactly 513 cycles (par=0 in HALT) or 514 cycles (par=1), from the first HALT cycle through the last WRITE cycle inclusive.
REQ-025 SHALL transfer exactly 256 bytes per DMA, idx 0..255 in ascending order, with no wrap into the next page (page $FF reads $FF00-$FFFF).
REQ-026 SHALL hold rdy=0 and busy=1 in HALT, ALIGN, READ and WRITE, and rdy=1 and busy=0 in IDLE.
REQ-027 SHALL return rdy to 1 in the first cycle after the final WRITE.
REQ-028 SHALL assert bus_master=1 only in READ and WRITE.
REQ-029 SHALL drive dma_rd=0, ppu_reg_cs=0 and dma_addr=16'h0000 outside the states that assert them.
REQ-030 SHALL drive ppu_data=dat at all times.
REQ-031 SHALL generate all outputs from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-032 While nres_in=0: state=IDLE, page=0, idx=0, dat=0, par=0; outputs rdy=1, busy=0, bus_master=0, dma_rd=0, ppu_reg_cs=0, dma_addr=0, ppu_data=0, ppu_reg_addr=3'd4.
REQ-033 Reset asserted mid-DMA SHALL abort the transfer immediately with no further PPU writes; after release, the block SHALL wait in IDLE for a new $4014 write.

Verification
REQ-034 Write $02 to $4014 with par=0 in HALT -> rdy=0 for 513 cycles; 256 ppu_reg_cs pulses carry mem[$0200..$02FF] in order; then rdy=1.
REQ-035 Same write issued one cycle later so par=1 in HALT -> 514 cycles, one ALIGN cycle, identical data.
REQ-036 Page $FF -> last dma_addr=$FFFF, no access to $0000, FSM returns to IDLE.
REQ-037 Second $4014 write injected mid-DMA -> ignored; page unchanged; still 256 writes total.
REQ-038 nres_in pulled low at byte 100 -> rdy=1 and ppu_reg_cs=0 asynchronously; after release no writes until a new trigger.
REQ-039 Write to $4013 or $2014 -> no state change; rdy stays 1.
